// File: rtl/counter_pkg.sv
// ============================================================================
//  counter_pkg : shared encodings and a width helper for counter_mod_n
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2(input int unsigned value);
    int          width;
    int unsigned top;
    width = 1;
    top   = (value > 0) ? value - 1 : 0;
    for (int i = 0; i < 32; i++) begin
      if ((top >> i) != 0) width = i + 1;
    end
    return width;
  endfunction

endpackage : counter_pkg

`default_nettype wire

// File: rtl/prescaler_tick.sv
// ============================================================================
//  prescaler_tick : emits one tick for every PRESCALE enabled cycles
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module prescaler_tick
  import counter_pkg::*;
#(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int            W    = clog2(PRESCALE);
  localparam logic [W-1:0]  LAST = W'(PRESCALE - 1);

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;
  logic         at_last;

  assign at_last = (pc_q == LAST);
  assign tick    = en & at_last;

  always_comb begin
    pc_d = pc_q;
    if (restart) begin
      pc_d = '0;
    end else if (en) begin
      pc_d = at_last ? '0 : pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule : prescaler_tick

`default_nettype wire

// File: rtl/counter_mod_n.sv
// ============================================================================
//  counter_mod_n : modulo-M up/down counter with prescaler, load/clear and
//                  wrap/saturate modes; registered ov pulse, combinational tc
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module counter_mod_n
  import counter_pkg::*;
#(
  parameter int N        = 8,
  parameter int M        = 256,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cnt,
  input  logic         dir,
  input  logic         mode,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         ov,
  output logic         tc
);

  generate
    if (N < 2 || N > 16) begin : g_bad_n
      $error("counter_mod_n: N must be in 2..16");
    end
    if (M < 2 || longint'(M) > (longint'(1) << N)) begin : g_bad_m
      $error("counter_mod_n: M must be in 2..2**N");
    end
    if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
      $error("counter_mod_n: PRESCALE must be in 1..65536");
    end
  endgenerate

  localparam logic [N-1:0] MAX = N'(M - 1);
  localparam logic [16:0]  M_W = 17'(M);

  logic [N-1:0] q_q, q_d;
  logic         ov_q, ov_d;
  logic         step;
  logic         at_max;
  logic         at_zero;

  generate
    if (PRESCALE > 1) begin : g_prescale
      prescaler_tick #(
        .PRESCALE (PRESCALE)
      ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .restart (clr | load),
        .en      (cnt),
        .tick    (step)
      );
    end else begin : g_no_prescale
      assign step = cnt;
    end
  endgenerate

  assign at_max  = (q_q == MAX);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d  = q_q;
    ov_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      // Out-of-range loads clamp so q never leaves 0..M-1.
      q_d = (17'(d) >= M_W) ? MAX : d;
    end else if (step) begin
      if (dir == DIR_UP) begin
        if (at_max) begin
          ov_d = 1'b1;
          q_d  = (mode == MODE_SAT) ? q_q : '0;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          ov_d = 1'b1;
          q_d  = (mode == MODE_SAT) ? q_q : MAX;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      ov_q <= ov_d;
    end
  end

  assign q  = q_q;
  assign ov = ov_q;
  assign tc = (dir == DIR_UP) ? at_max : at_zero;

endmodule : counter_mod_n

`default_nettype wire

// File: tb/tb_counter_mod_n.sv
// ============================================================================
//  tb_counter_mod_n : directed self-checking bench for counter_mod_n
//  Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_counter_mod_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cnt = 1'b0;
  logic       dir = 1'b1;
  logic       mode = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] d8 = '0;
  logic [3:0] d4 = '0;

  logic [7:0] qa;
  logic       ova, tca;
  logic [3:0] qb, qc;
  logic       ovb, tcb, ovc, tcc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  counter_mod_n #(.N(8), .M(256), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .cnt(cnt), .dir(dir), .mode(mode), .clr(clr),
    .load(load), .d(d8), .q(qa), .ov(ova), .tc(tca)
  );

  counter_mod_n #(.N(4), .M(10), .PRESCALE(1)) u_b (
    .clk(clk), .rst(rst), .cnt(cnt), .dir(dir), .mode(mode), .clr(clr),
    .load(load), .d(d4), .q(qb), .ov(ovb), .tc(tcb)
  );

  counter_mod_n #(.N(4), .M(10), .PRESCALE(3)) u_c (
    .clk(clk), .rst(rst), .cnt(cnt), .dir(dir), .mode(mode), .clr(clr),
    .load(load), .d(d4), .q(qc), .ov(ovc), .tc(tcc)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cnt = 1'b0; clr = 1'b0; load = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // One cnt-high cycle followed by one idle cycle.
  task automatic pulse();
    cnt = 1'b1;
    tick();
    cnt = 1'b0;
    tick();
  endtask

  int exp_b[5];
  int exp_ov[5];

  initial begin
    // ---- 1: 8-bit full-range up count with wrap
    dir = 1'b1; mode = 1'b0;
    do_reset();
    check("a_reset_q", qa, 0);
    check("a_reset_ov", ova, 0);
    check("a_reset_tc", tca, 0);
    check("c_reset_q", qc, 0);
    cnt = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      tick();
      check($sformatf("a_up_q_%0d", i), qa, i % 256);
      check($sformatf("a_up_ov_%0d", i), ova, (i == 256) ? 1 : 0);
      check($sformatf("a_up_tc_%0d", i), tca, ((i % 256) == 255) ? 1 : 0);
    end
    cnt = 1'b0;

    // ---- 2: M=10 down wrap from 3
    do_reset();
    dir = 1'b0; mode = 1'b0; load = 1'b1; d4 = 4'd3;
    tick();
    load = 1'b0;
    check("b_load3", qb, 3);
    exp_b  = '{2, 1, 0, 9, 8};
    exp_ov = '{0, 0, 0, 1, 0};
    cnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("b_down_q_%0d", i), qb, exp_b[i]);
      check($sformatf("b_down_ov_%0d", i), ovb, exp_ov[i]);
      check($sformatf("b_down_tc_%0d", i), tcb, (exp_b[i] == 0) ? 1 : 0);
    end
    cnt = 1'b0;

    // ---- 3: saturate up from 7, then reverse
    dir = 1'b1; mode = 1'b1; load = 1'b1; d4 = 4'd7;
    tick();
    load = 1'b0;
    check("b_load7", qb, 7);
    exp_b  = '{8, 9, 9, 9, 9};
    exp_ov = '{0, 0, 1, 1, 1};
    cnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("b_sat_q_%0d", i), qb, exp_b[i]);
      check($sformatf("b_sat_ov_%0d", i), ovb, exp_ov[i]);
    end
    cnt = 1'b0;
    check("b_sat_tc_up", tcb, 1);
    dir = 1'b0;
    #1;
    check("b_tc_comb_dirflip", tcb, 0);
    cnt = 1'b1;
    tick();
    cnt = 1'b0;
    check("b_sat_rev_q", qb, 8);
    check("b_sat_rev_ov", ovb, 0);
    load = 1'b1; d4 = 4'd0;
    tick();
    load = 1'b0; cnt = 1'b1;
    tick();
    cnt = 1'b0;
    check("b_sat_down_q", qb, 0);
    check("b_sat_down_ov", ovb, 1);
    tick();
    check("b_ov_single", ovb, 0);

    // ---- 4: prescale by 3
    dir = 1'b1; mode = 1'b0;
    do_reset();
    pulse(); pulse();
    check("c_pre_2", qc, 0);
    pulse();
    check("c_pre_3", qc, 1);
    pulse(); pulse(); pulse();
    check("c_pre_6", qc, 2);
    pulse();
    check("c_pre_7", qc, 2);
    load = 1'b1; d4 = 4'd0;
    tick();
    load = 1'b0;
    check("c_load0", qc, 0);
    pulse(); pulse();
    check("c_restart_2", qc, 0);
    pulse();
    check("c_restart_3", qc, 1);

    // ---- 5: priority and clamp
    load = 1'b1; d4 = 4'd6;
    tick();
    load = 1'b0;
    check("b_pre_prio", qb, 6);
    rst = 1'b1; clr = 1'b1; load = 1'b1; cnt = 1'b1; d4 = 4'd5;
    tick();
    rst = 1'b0; clr = 1'b0; load = 1'b0; cnt = 1'b0;
    check("b_prio_rst", qb, 0);
    check("b_prio_rst_ov", ovb, 0);
    load = 1'b1; d4 = 4'd6;
    tick();
    clr = 1'b1; load = 1'b1; d4 = 4'd5;
    tick();
    clr = 1'b0; load = 1'b0;
    check("b_clr_over_load", qb, 0);
    load = 1'b1; d4 = 4'd12;
    tick();
    check("b_clamp12", qb, 9);
    d4 = 4'd9;
    tick();
    check("b_load_max", qb, 9);
    d4 = 4'd15; d8 = 8'd255;
    tick();
    load = 1'b0;
    check("b_clamp15", qb, 9);
    check("a_load255", qa, 255);
    load = 1'b1; d4 = 4'd6;
    tick();
    load = 1'b0;
    check("c_load6", qc, 6);
    pulse(); pulse();
    check("c_mid_prescale", qc, 6);
    rst = 1'b1; cnt = 1'b1;
    tick();
    rst = 1'b0; cnt = 1'b0;
    check("c_rst_mid_q", qc, 0);
    pulse(); pulse();
    check("c_rst_pc_2", qc, 0);
    pulse();
    check("c_rst_pc_3", qc, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_counter_mod_n

`default_nettype wire

// File: doc/counter_mod_n.md
Name: counter_mod_n

Overview:
- Parametrised modulo-M up/down counter with count-enable prescaler, synchronous load/clear and a selectable wrap/saturate mode.
- Successor to the fixed 8-bit counter in the basic-behaviour datapath.
- Used for timing, servo pulse generation and step sequencing in the robot controllers.
- Provides a registered one-cycle overflow pulse and a combinational terminal-count flag.

Parameters:
- N, 8: counter width in bits; legal range 2..16.
- M, 256: modulus, so q runs 0..M-1; legal range 2..2**N; elaboration error otherwise.
- PRESCALE, 1: number of cnt-high cycles per counter step; legal range 1..65536; 1 means every cnt-high cycle steps.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- cnt  in  1  count enable; sampled each clk.
- dir  in  1  direction: 1 = up, 0 = down.
- mode  in  1  0 = wrap, 1 = saturate.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of d.
- d  in  N  load value.
- q  out  N  current count, registered.
- ov  out  1  one-cycle pulse on wrap or saturation hit, registered.
- tc  out  1  terminal count, combinational: (dir & q==M-1) | (!dir & q==0).

Behaviour:
- Reset (rst=1 at edge): q=0, ov=0, prescaler count=0. Applies regardless of other inputs, including mid-prescale.
- Priority per edge: rst > clr > load > step. Only the highest-priority active action takes effect.
- clr: q=0, ov=0, prescaler=0.
- load: q = (d >= M) ? M-1 : d. Out-of-range loads clamp to M-1. ov=0, prescaler=0.
- Prescaler, when no rst/clr/load is active:
  - Each cycle with cnt=1, if pc==PRESCALE-1 then pc=0 and step=1; else pc=pc+1.
  - cnt=0 holds pc.
  - dir and mode changes do not affect pc.
  - PRESCALE=1 removes the prescaler register, so step=cnt.
- Step, up (dir=1):
  - q<M-1: q=q+1.
  - q==M-1, wrap mode: q=0, ov=1.
  - q==M-1, saturate mode: q holds, ov=1.
- Step, down (dir=0):
  - q>0: q=q-1.
  - q==0, wrap mode: q=M-1, ov=1.
  - q==0, saturate mode: q holds, ov=1.
- ov is high exactly one cycle, coincident with the wrapped or held q; ov=0 on every edge without a boundary step.
  - Held cnt in saturate mode at the bound gives ov=1 on every stepping edge (one pulse per step).
- Latency: q and ov update one clk after the sampled inputs. tc follows q and dir combinationally with zero latency.
- Arithmetic: the next-value compare is done at N bits against M-1, so M=2**N wraps naturally with no extra bit. The counter never holds a value >= M, and there is no intermediate M state.
- Simultaneous events:
  - load and cnt in the same cycle: load wins and the prescaler restarts at 0.
  - clr and load in the same cycle: clr wins.
  - A change of dir in the same cycle as a step uses the new dir.

Decomposition:
- Shared package counter_pkg:
  - DIR_UP=1, DIR_DOWN=0.
  - MODE_WRAP=0, MODE_SAT=1.
  - clog2 helper function for the prescaler width.
- One natural sub-module, prescaler_tick (parameter PRESCALE; ports clk, rst, restart, en, tick).
  - Reusable by other timing blocks.
  - The top instantiates it only when PRESCALE>1.

Test Plan:
1. N=8, M=256, PRESCALE=1, up, wrap; rst then cnt=1 for 257 cycles -> q counts 0..255, then 0 with ov=1 for one cycle; tc=1 only while q=255.
2. N=4, M=10, down, wrap; load d=3, then cnt for 5 cycles -> q=3,2,1,0,9,8; ov=1 only in the cycle q becomes 9.
3. M=10, saturate, up; load d=7, then cnt for 5 cycles -> q=8,9,9,9,9; ov=1 on each of the last 3 steps; switching dir=0 then gives q=8 with ov=0.
4. M=10, PRESCALE=3, up; cnt pulses on 7 non-consecutive cycles -> q steps to 1 after the 3rd pulse and to 2 after the 6th; a load d=0 after the 7th pulse clears pc, so 3 further pulses are needed before q=1.
5. Priority and clamp checks:
   - rst=clr=load=cnt=1 -> q=0.
   - clr=load=1 with d=5 -> q=0.
   - load d=12 with M=10 -> q=9.
   - rst asserted at q=6 mid-prescale -> q=0 and pc=0 next cycle.
